// File: rtl/imem_prog_ctrl.sv
// Run-time instruction memory loader: assembles little-endian bytes into 32-bit
// words, writes them from address 0 upward and holds the core while doing so.
module imem_prog_ctrl #(
  parameter int IMEM_WORDS     = 256,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int AW            = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_start,
  input  logic [AW:0]   prog_len,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic [AW-1:0] fetch_addr,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] MAX_LEN  = (AW+1)'(IMEM_WORDS);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t        state, state_n;
  logic [AW:0]   len_q;
  logic [AW:0]   word_cnt;
  logic [AW-1:0] wr_addr;
  logic [1:0]    byte_cnt;
  logic [31:0]   shift_q;
  logic [31:0]   to_cnt;
  logic          err_n;
  logic          len_ok;
  logic          accept;
  logic          timeout_hit;

  // Handshake: a byte transfers on any rising edge where byte_valid && byte_ready;
  // byte_ready depends only on state, never on byte_valid.
  assign byte_ready  = (state == LOAD);
  assign accept      = byte_ready && byte_valid;
  assign len_ok      = (prog_len != '0) && (prog_len <= MAX_LEN);
  assign timeout_hit = TO_EN && (state == LOAD) && !accept && (to_cnt == TO_LAST);

  assign mem_we    = (state == WRITE);
  assign mem_addr  = (state == LOAD || state == WRITE) ? wr_addr : fetch_addr;
  assign cpu_hold  = (state != IDLE);
  assign busy      = (state == LOAD || state == WRITE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (prog_start) begin
          if (len_ok) state_n = LOAD;
          else        err_n   = 1'b1;
        end
      end
      LOAD: begin
        if (accept && byte_cnt == 2'd3) begin
          state_n = WRITE;
        end else if (timeout_hit) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      WRITE: state_n = (word_cnt + 1'b1 == len_q) ? DONE : LOAD;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      err       <= 1'b0;
      len_q     <= '0;
      word_cnt  <= '0;
      wr_addr   <= '0;
      byte_cnt  <= '0;
      shift_q   <= '0;
      to_cnt    <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      err   <= err_n;
      case (state)
        IDLE: begin
          if (prog_start && len_ok) begin
            len_q    <= prog_len;
            word_cnt <= '0;
            wr_addr  <= '0;
            byte_cnt <= '0;
            to_cnt   <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            shift_q  <= {byte_data, shift_q[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            to_cnt   <= '0;
            if (byte_cnt == 2'd3) mem_wdata <= {byte_data, shift_q[31:8]};
          end else if (timeout_hit) begin
            // Partial word is dropped; words already written stay in memory.
            byte_cnt <= '0;
            to_cnt   <= '0;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        WRITE: begin
          wr_addr  <= wr_addr + 1'b1;
          word_cnt <= word_cnt + 1'b1;
          to_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_prog_ctrl.md
Name: imem_prog_ctrl

Overview:
- Programs the instruction memory at run time from an 8-bit byte stream (UART/debug loader side).
- Owns the memory address mux: the core fetch address passes through in IDLE; the loader address is selected while programming.
- Holds the core stalled while programming runs.
- Assembles little-endian bytes into 32-bit words and writes consecutive word addresses from 0. Reports completion, bad requests and stream timeout.

Parameters:
- IMEM_WORDS, 256, depth of instruction memory in words. AW = $clog2(IMEM_WORDS) is derived.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes while loading. 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- prog_start  input  1  one-cycle request to begin programming.
- prog_len  input  AW+1  number of words to load, sampled with prog_start. Valid range 1..IMEM_WORDS.
- byte_valid  input  1  loader byte available.
- byte_data  input  8  loader byte.
- byte_ready  output  1  controller accepts byte_data this cycle.
- fetch_addr  input  AW  core fetch word index.
- mem_addr  output  AW  address to instruction memory.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_wdata  output  32  assembled write word.
- cpu_hold  output  1  stalls the core; high whenever state != IDLE.
- busy  output  1  programming in progress.
- done  output  1  one-cycle pulse when the last word has been written.
- err  output  1  one-cycle pulse on rejected request or timeout.

Behaviour:
- States: IDLE, LOAD, WRITE, DONE.
- Reset values: state=IDLE, byte_ready=0, mem_we=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, err=0. The byte counter, word counter, write address and timeout counter are all 0.
- IDLE:
  - mem_addr=fetch_addr (combinational pass-through); byte_ready=0.
  - On prog_start with 1<=prog_len<=IMEM_WORDS: latch prog_len, clear counters, go to LOAD next cycle.
  - On prog_start with prog_len=0 or prog_len>IMEM_WORDS: err=1 next cycle, stay in IDLE.
- LOAD:
  - byte_ready=1. A byte is accepted on a cycle with byte_valid&byte_ready.
  - Bytes shift in little-endian: the first byte goes to [7:0], the fourth to [31:24].
  - The 2-bit byte counter wraps 3->0. On the 4th accepted byte, mem_wdata is registered and the state moves to WRITE.
- WRITE:
  - One cycle only: mem_we=1, mem_addr=write address, byte_ready=0.
  - Next cycle: write address +1 and word count +1.
  - If word count+1 == latched prog_len, go to DONE; otherwise return to LOAD.
- DONE: one cycle with done=1 and cpu_hold still 1, then IDLE. The core resumes the cycle after DONE.
- mem_addr = write address in LOAD and WRITE, fetch_addr in IDLE and DONE.
- busy = 1 in LOAD and WRITE.
- Write-address arithmetic is AW bits. prog_len=IMEM_WORDS writes the last index IMEM_WORDS-1 and stops with no wrap. A wrap is unreachable by construction.
- Timeout:
  - In LOAD the counter increments each cycle with no accepted byte and clears on acceptance.
  - When it reaches TIMEOUT_CYCLES (nonzero): err=1, go to IDLE, discard the partial word. Words already written remain in memory.
- prog_start while not in IDLE is ignored: no err, latched length unchanged.
- Simultaneous events:
  - prog_start arriving in the same cycle as DONE is ignored.
  - A byte presented during WRITE is not accepted; it is taken in the following LOAD cycle.
- Reset asserted mid-operation forces IDLE asynchronously, releases cpu_hold and drops any partial word. Memory contents are not cleared.

Test Plan:
- Basic load: prog_start with prog_len=2, bytes 13,00,00,00,93,00,10,00 with byte_valid held high -> mem_we pulses at addr 0 with 0x00000013, then at addr 1 with 0x00100093. Each write occurs the cycle after the 4th byte. done pulses once, then cpu_hold=0 and mem_addr tracks fetch_addr=5.
- Bad length: prog_len=0, then prog_len=IMEM_WORDS+1 (257) -> err pulses one cycle each time, no mem_we, cpu_hold stays 0.
- Backpressure/gaps: 4 bytes with byte_valid toggling every other cycle, plus a byte presented during WRITE -> byte accepted only when byte_ready=1 and the word assembles correctly. With prog_start pulsed mid-load, the latched length is unchanged.
- Full depth: prog_len=256, word i = i -> 256 writes at addresses 0..255, last write at 255, no wrap, done once.
- Timeout: TIMEOUT_CYCLES=20, send 6 bytes then stop -> one word written at addr 0, err pulses 20 cycles after the 6th byte, state IDLE, cpu_hold=0.
- Reset mid-load: assert rst after 2 bytes -> all outputs return to reset values immediately (asynchronously). A fresh prog_len=1 load afterwards writes addr 0 correctly.
